// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package : core_pkg
// Brief   : Shared core widths, arbiter state encoding and memory command type.
// Rev     : 1.0
// ============================================================================
package core_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_WAIT_IF = 2'd1,
        ARB_WAIT_D  = 2'd2
    } arb_state_e;

    // Request fields presented to the shared memory by whichever port wins.
    typedef struct packed {
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_cmd_t;

    // Instruction fetch is always a full-word read.
    function automatic mem_cmd_t fetch_cmd(input logic [ADDR_WIDTH-1:0] addr);
        mem_cmd_t cmd;
        cmd.we    = 1'b0;
        cmd.be    = '1;
        cmd.addr  = addr;
        cmd.wdata = '0;
        return cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_port_arbiter_if
// Brief     : Fetch port, data port and shared-memory port bundle.
// Rev       : 1.0
// ============================================================================
interface mem_port_arbiter_if;
    import core_pkg::*;

    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [BE_WIDTH-1:0]   d_be;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [BE_WIDTH-1:0]   mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Requesters plus memory side.
    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module : arb_starve_cnt
// Brief  : Saturating count of data wins taken while a fetch was waiting.
// Rev    : 1.0
// ============================================================================
module arb_starve_cnt #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int               CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_limit = (r_cnt == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Shares one single-port memory between fetch and data ports, data
//          first, with a fetch starvation guard; one transaction in flight.
// Rev    : 1.0
// ============================================================================
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_e r_state;
    arb_state_e w_state_next;

    logic     w_pick_if;
    logic     w_pick_d;
    logic     w_if_win;
    logic     w_d_win;
    logic     w_starve_inc;
    logic     w_starve_clr;
    logic     w_at_limit;
    mem_cmd_t w_cmd;

    arb_starve_cnt #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (w_starve_inc),
        .clr      (w_starve_clr),
        .at_limit (w_at_limit)
    );

    // Data normally wins; fetch wins when alone or once it has been starved.
    assign w_pick_if = bus.if_req & (~bus.d_req | w_at_limit);
    assign w_pick_d  = bus.d_req & ~w_pick_if;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_if_win      = 1'b0;
        w_d_win       = 1'b0;
        w_starve_inc  = 1'b0;
        w_starve_clr  = 1'b0;
        w_cmd         = '0;
        bus.mem_req   = 1'b0;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = '0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = '0;

        // Everything stays quiet while reset is asserted.
        if (rst_n) begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_pick_if) begin
                        w_cmd = fetch_cmd(bus.if_addr);
                    end else if (w_pick_d) begin
                        w_cmd.we    = bus.d_we;
                        w_cmd.be    = bus.d_be;
                        w_cmd.addr  = bus.d_addr;
                        w_cmd.wdata = bus.d_wdata;
                    end
                    bus.mem_req  = bus.if_req | bus.d_req;
                    w_if_win     = w_pick_if & bus.mem_gnt;
                    w_d_win      = w_pick_d & bus.mem_gnt;
                    bus.if_gnt   = w_if_win;
                    bus.d_gnt    = w_d_win;
                    w_starve_clr = w_if_win;
                    w_starve_inc = w_d_win & bus.if_req;
                    if (w_if_win) begin
                        w_state_next = ARB_WAIT_IF;
                    end else if (w_d_win) begin
                        w_state_next = ARB_WAIT_D;
                    end
                end
                ARB_WAIT_IF: begin
                    bus.if_rvalid = bus.mem_rvalid;
                    bus.if_rdata  = bus.mem_rvalid ? bus.mem_rdata : '0;
                    if (bus.mem_rvalid) begin
                        w_state_next = ARB_IDLE;
                    end
                end
                ARB_WAIT_D: begin
                    bus.d_rvalid = bus.mem_rvalid;
                    bus.d_rdata  = bus.mem_rvalid ? bus.mem_rdata : '0;
                    if (bus.mem_rvalid) begin
                        w_state_next = ARB_IDLE;
                    end
                end
                default: begin
                    w_state_next = ARB_IDLE;
                end
            endcase
        end

        bus.mem_we    = w_cmd.we;
        bus.mem_be    = w_cmd.be;
        bus.mem_addr  = w_cmd.addr;
        bus.mem_wdata = w_cmd.wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed vector table, corner sequences and randomized traffic
//          against a transaction-level arbitration model.
// Rev    : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    import core_pkg::*;

    localparam int LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
    } stim_t;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic [3:0]  mem_be;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        if_gnt;
        logic        d_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        d_rvalid;
        logic [31:0] d_rdata;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t r;
    } vec_t;

    int    total = 0;
    int    bad   = 0;
    vec_t  vq[$];
    int    ref_owner;   // 0 = free, 1 = fetch in flight, 2 = data in flight
    int    ref_wins;    // data wins in a row while a fetch was waiting
    stim_t cur;
    bit    if_pend;
    bit    d_pend;
    bit    wins_if[10];
    int    nwin;

    function automatic stim_t mk_s(logic ir, logic [31:0] ia, logic dr, logic dwe,
                                   logic [3:0] dbe, logic [31:0] da, logic [31:0] dwd,
                                   logic mg, logic mv, logic [31:0] md);
        stim_t s;
        s.if_req = ir;   s.if_addr = ia;
        s.d_req = dr;    s.d_we = dwe;     s.d_be = dbe;
        s.d_addr = da;   s.d_wdata = dwd;
        s.mem_gnt = mg;  s.mem_rvalid = mv; s.mem_rdata = md;
        return s;
    endfunction

    function automatic resp_t mk_r(logic mrq, logic mwe, logic [3:0] mbe, logic [31:0] ma,
                                   logic [31:0] mwd, logic ig, logic dg, logic iv,
                                   logic [31:0] ird, logic dv, logic [31:0] drd);
        resp_t r;
        r.mem_req = mrq; r.mem_we = mwe; r.mem_be = mbe;
        r.mem_addr = ma; r.mem_wdata = mwd;
        r.if_gnt = ig;   r.d_gnt = dg;
        r.if_rvalid = iv; r.if_rdata = ird;
        r.d_rvalid = dv;  r.d_rdata = drd;
        return r;
    endfunction

    task automatic apply(input stim_t s);
        bus.if_req     = s.if_req;
        bus.if_addr    = s.if_addr;
        bus.d_req      = s.d_req;
        bus.d_we       = s.d_we;
        bus.d_be       = s.d_be;
        bus.d_addr     = s.d_addr;
        bus.d_wdata    = s.d_wdata;
        bus.mem_gnt    = s.mem_gnt;
        bus.mem_rvalid = s.mem_rvalid;
        bus.mem_rdata  = s.mem_rdata;
    endtask

    function automatic resp_t sample();
        resp_t r;
        r.mem_req   = bus.mem_req;
        r.mem_we    = bus.mem_we;
        r.mem_be    = bus.mem_be;
        r.mem_addr  = bus.mem_addr;
        r.mem_wdata = bus.mem_wdata;
        r.if_gnt    = bus.if_gnt;
        r.d_gnt     = bus.d_gnt;
        r.if_rvalid = bus.if_rvalid;
        r.if_rdata  = bus.if_rdata;
        r.d_rvalid  = bus.d_rvalid;
        r.d_rdata   = bus.d_rdata;
        return r;
    endfunction

    task automatic check(input string name, input resp_t got, input resp_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Reference: whoever is free to arbitrate picks data unless the fetch
    // port has already lost LIMIT times in a row; one transaction at a time.
    function automatic resp_t ref_out(input stim_t s);
        resp_t r = '0;
        bit    fetch_wins;
        if (ref_owner == 0) begin
            if (s.if_req || s.d_req) begin
                fetch_wins = s.if_req && (!s.d_req || ref_wins >= LIMIT);
                r.mem_req  = 1'b1;
                if (fetch_wins) begin
                    r.mem_be   = 4'hF;
                    r.mem_addr = s.if_addr;
                    r.if_gnt   = s.mem_gnt;
                end else begin
                    r.mem_we    = s.d_we;
                    r.mem_be    = s.d_be;
                    r.mem_addr  = s.d_addr;
                    r.mem_wdata = s.d_wdata;
                    r.d_gnt     = s.mem_gnt;
                end
            end
        end else if (s.mem_rvalid) begin
            if (ref_owner == 1) begin
                r.if_rvalid = 1'b1;
                r.if_rdata  = s.mem_rdata;
            end else begin
                r.d_rvalid = 1'b1;
                r.d_rdata  = s.mem_rdata;
            end
        end
        return r;
    endfunction

    task automatic ref_step(input stim_t s, input resp_t r);
        if (ref_owner == 0) begin
            if (r.if_gnt) begin
                ref_owner = 1;
                ref_wins  = 0;
            end else if (r.d_gnt) begin
                ref_owner = 2;
                if (s.if_req && ref_wins < LIMIT) ref_wins++;
            end
        end else if (s.mem_rvalid) begin
            ref_owner = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed per-cycle table, starting from a freshly reset arbiter.
        vq.push_back('{mk_s(1, 32'h10, 0, 0, 4'h0, 0, 0, 1, 0, 0),
                       mk_r(1, 0, 4'hF, 32'h10, 0, 1, 0, 0, 0, 0, 0)});
        vq.push_back('{mk_s(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0), '0});
        vq.push_back('{mk_s(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h002081B3),
                       mk_r(0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h002081B3, 0, 0)});
        vq.push_back('{mk_s(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hDEAD), '0});
        vq.push_back('{mk_s(1, 32'h14, 1, 1, 4'hF, 32'h84, 32'd50, 1, 0, 0),
                       mk_r(1, 1, 4'hF, 32'h84, 32'd50, 0, 1, 0, 0, 0, 0)});
        vq.push_back('{mk_s(1, 32'h14, 0, 0, 4'h0, 0, 0, 1, 0, 0), '0});
        vq.push_back('{mk_s(1, 32'h14, 0, 0, 4'h0, 0, 0, 0, 1, 32'h55),
                       mk_r(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'h55)});
        vq.push_back('{mk_s(1, 32'h14, 0, 0, 4'h0, 0, 0, 1, 0, 0),
                       mk_r(1, 0, 4'hF, 32'h14, 0, 1, 0, 0, 0, 0, 0)});
        vq.push_back('{mk_s(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h1234),
                       mk_r(0, 0, 4'h0, 0, 0, 0, 0, 1, 32'h1234, 0, 0)});
        for (int i = 0; i < 3; i++) begin
            vq.push_back('{mk_s(0, 0, 1, 0, 4'h3, 32'h84, 32'h77, 0, 0, 0),
                           mk_r(1, 0, 4'h3, 32'h84, 32'h77, 0, 0, 0, 0, 0, 0)});
        end
        vq.push_back('{mk_s(0, 0, 1, 0, 4'h3, 32'h84, 32'h77, 1, 0, 0),
                       mk_r(1, 0, 4'h3, 32'h84, 32'h77, 0, 1, 0, 0, 0, 0)});
        vq.push_back('{mk_s(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hCAFE),
                       mk_r(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE)});

        // Reset with every request asserted: all outputs must be low.
        rst_n = 1'b0;
        apply(mk_s(1, 32'h10, 1, 1, 4'hF, 32'h84, 32'h1, 1, 1, 32'hFFFF));
        @(posedge clk);
        @(posedge clk);
        #4;
        check("reset_outputs", sample(), '0);
        rst_n = 1'b1;
        apply('0);

        foreach (vq[i]) begin
            @(posedge clk); #1;
            apply(vq[i].s);
            #3;
            check($sformatf("vec%0d", i), sample(), vq[i].r);
        end

        // Reset while a data transaction is in flight.
        @(posedge clk); #1;
        apply(mk_s(1, 32'h20, 1, 0, 4'hF, 32'h90, 0, 1, 0, 0));
        #3;
        check("rw_grant", sample(), mk_r(1, 0, 4'hF, 32'h90, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk_s(1, 32'h20, 1, 0, 4'hF, 32'h90, 0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("rw_rst_out", sample(), '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(mk_s(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hBEEF));
        #3;
        check("rw_late_rvalid", sample(), '0);
        @(posedge clk); #1;
        apply(mk_s(0, 0, 1, 0, 4'hF, 32'h88, 0, 1, 0, 0));
        #3;
        check("rw_regrant", sample(), mk_r(1, 0, 4'hF, 32'h88, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk_s(0, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'h77));
        #3;
        check("rw_resp", sample(), mk_r(0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 32'h77));

        // Both ports requesting continuously: every fifth grant goes to fetch.
        nwin = 0;
        for (int c = 0; c < 100 && nwin < 10; c++) begin
            @(posedge clk); #1;
            apply(mk_s(1, 32'h40, 1, 0, 4'hF, 32'hA0, 0, 1, 1, 32'(c)));
            #3;
            if (bus.if_gnt || bus.d_gnt) begin
                wins_if[nwin] = bus.if_gnt;
                nwin++;
            end
        end
        check_int("starve_grant_count", nwin, 10);
        for (int k = 0; k < nwin; k++) begin
            check_int($sformatf("starve_win%0d_is_fetch", k), int'(wins_if[k]), ((k % 5) == 4) ? 1 : 0);
        end

        // Randomized traffic against the reference model.
        @(posedge clk); #1;
        rst_n = 1'b0;
        apply('0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        ref_owner = 0;
        ref_wins  = 0;
        if_pend   = 1'b0;
        d_pend    = 1'b0;
        cur       = '0;
        for (int n = 0; n < 3000; n++) begin
            resp_t exp;
            @(posedge clk); #1;
            if (!if_pend && ($urandom_range(1, 0) == 1)) begin
                if_pend     = 1'b1;
                cur.if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_pend && ($urandom_range(1, 0) == 1)) begin
                d_pend      = 1'b1;
                cur.d_we    = 1'($urandom);
                cur.d_be    = 4'($urandom);
                cur.d_addr  = $urandom;
                cur.d_wdata = $urandom;
            end
            cur.if_req     = if_pend;
            cur.d_req      = d_pend;
            cur.mem_gnt    = ($urandom_range(3, 0) != 0);
            cur.mem_rvalid = 1'($urandom);
            cur.mem_rdata  = $urandom;
            apply(cur);
            #3;
            exp = ref_out(cur);
            check($sformatf("rand%0d", n), sample(), exp);
            ref_step(cur, exp);
            if (exp.if_gnt) if_pend = 1'b0;
            if (exp.d_gnt)  d_pend  = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive data-port wins after which a waiting fetch request is forced to win.
REQ-002 SHALL use widths DATA_WIDTH=32 and ADDR_WIDTH=32 from core_pkg.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 if_req / if_addr  in  1 / 32  fetch read request and word address, held stable until granted.
REQ-006 if_gnt / if_rvalid / if_rdata  out  1 / 1 / 32  fetch grant, response valid and read data.
REQ-007 d_req / d_we / d_be / d_addr / d_wdata  in  1 / 1 / 4 / 32 / 32  data-port request, held stable until granted.
REQ-008 d_gnt / d_rvalid / d_rdata  out  1 / 1 / 32  data grant, response valid (read data or write acknowledge) and read data.
REQ-009 mem_req / mem_we / mem_be / mem_addr / mem_wdata  out  1 / 1 / 4 / 32 / 32  request to the shared single-port memory.
REQ-010 mem_gnt / mem_rvalid / mem_rdata  in  1 / 1 / 32  memory accept, response valid and read data.

Function
REQ-011 SHALL implement an FSM with states IDLE, WAIT_IF and WAIT_D, and SHALL allow at most one outstanding memory transaction.
REQ-012 In IDLE, the winner SHALL be: d if only d_req is high; IF if only if_req is high; if both are high, d wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
REQ-013 In IDLE, the mem_* request fields SHALL be driven combinationally from the winner (mem_we=0 and mem_be=4'hF for fetch), with mem_req=if_req|d_req.
REQ-014 The winner's grant SHALL equal mem_gnt & mem_req; the loser's grant SHALL be 0.
REQ-015 A grant to IF SHALL move the FSM to WAIT_IF, and a grant to d SHALL move it to WAIT_D; if mem_gnt=0, the FSM SHALL stay in IDLE with the request held.
REQ-016 In WAIT_*, mem_req, if_gnt and d_gnt SHALL be 0.
REQ-017 In WAIT_*, mem_rvalid SHALL be routed the same cycle to the owner's rvalid, and the owner's rdata SHALL equal mem_rdata; the FSM SHALL then return to IDLE.
REQ-018 Minimum transaction length SHALL be 2 cycles (grant, then rvalid); a new request SHALL be arbitrated no earlier than the cycle after rvalid.
REQ-019 The non-owner's rvalid SHALL be 0, and each rdata output SHALL be 0 whenever its rvalid is 0.
REQ-020 mem_rvalid SHALL be ignored while in IDLE.
REQ-021 starve_cnt SHALL be 0..STARVE_LIMIT, SHALL increment when d is granted while if_req=1, SHALL clear to 0 on an IF grant, and SHALL saturate at STARVE_LIMIT.
REQ-022 A d grant while if_req=0 SHALL leave starve_cnt unchanged.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE and starve_cnt=0.
REQ-024 While rst_n=0, all outputs SHALL be 0.
REQ-025 A transaction in flight at reset SHALL be abandoned, and its late mem_rvalid SHALL not be forwarded (REQ-020).

Structure
REQ-026 core_pkg SHALL add the typedef arb_state_e {ARB_IDLE, ARB_WAIT_IF, ARB_WAIT_D} and the constant BE_WIDTH=DATA_WIDTH/8.
REQ-027 The starvation counter SHALL be a sub-module arb_starve_cnt (inputs: inc, clr; output: at_limit), and the FSM and muxing SHALL stay in mem_port_arbiter.

Verification
REQ-028 Fetch only: if_req=1, if_addr=0x10, mem_gnt=1, mem_rvalid two cycles later with 0x002081B3 -> if_gnt for 1 cycle, then if_rvalid=1 with if_rdata=0x002081B3, d_* outputs 0.
REQ-029 Simultaneous requests: fetch 0x14 and store d_we=1, d_addr=0x84, d_wdata=50 -> mem_we=1, mem_be=4'hF, mem_addr=0x84, d_gnt=1, if_gnt=0; fetch granted in the first IDLE cycle after d_rvalid.
REQ-030 Starvation (STARVE_LIMIT=4): d_req and if_req held high continuously -> 4 d grants, 5th grant to IF, starve_cnt returns to 0, pattern repeats.
REQ-031 Backpressure: mem_gnt=0 for 3 cycles with d_req=1, d_addr=0x84 -> mem_req=1 and mem_addr=0x84 stable, no grant, state IDLE; grant on the 4th cycle.
REQ-032 Reset in WAIT_D: rst_n=0 for 1 cycle -> outputs 0 immediately; a mem_rvalid=1 arriving afterwards produces no d_rvalid.
